// File: rtl/down_count_timer_if.sv
// Control/status bundle for the down-count timer: the master drives the load and
// control strobes, and the slave (the timer) returns the count and status flags.
interface down_count_timer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load_val, start, stop, pause, auto_reload,
    input  count, busy, tc, done
  );

  modport slave (
    input  load_val, start, stop, pause, auto_reload,
    output count, busy, tc, done
  );
endinterface

// File: rtl/down_count_timer.sv
// Loadable, pausable down-counter with a one-cycle terminal-count pulse.
// It either stops in DONE or auto-reloads its start value for periodic operation.
module down_count_timer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  down_count_timer_if.slave    tif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q,     tc_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             load_ok;

  // A zero load value is never accepted, so a RUN count is always at least 1.
  assign load_ok = tif.start && (tif.load_val != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (tif.stop) begin
          state_d = IDLE;
        end else if (!tif.pause) begin
          if (count_q == WIDTH'(1)) begin
            tc_d = 1'b1;
            if (tif.auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = DONE;
            end
          end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      IDLE, DONE: begin
        if (tif.stop) begin
          state_d = IDLE;
        end else if (load_ok) begin
          count_d  = tif.load_val;
          reload_d = tif.load_val;
          state_d  = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign tif.count = count_q;
  assign tif.busy  = busy_q;
  assign tif.tc    = tc_q;
  assign tif.done  = done_q;

endmodule

// File: doc/down_count_timer.md
Name: down_count_timer

Overview:
- Loadable, pausable down-counter: the count-down counterpart to the team's free-running 4-bit up-counter.
- Loaded with a start value on a start strobe, it decrements once per unpaused cycle and flags terminal count.
- It either stops in DONE or auto-reloads for periodic operation.
- Used as the timeout/period generator beside the up-counter in the lab designs.

Parameters:
- WIDTH, 4, counter and load value width in bits.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- load_val  input  WIDTH  start value; sampled only on an accepted start.
- start  input  1  single-cycle start strobe.
- stop  input  1  abort; returns to IDLE.
- pause  input  1  level; holds count while in RUN.
- auto_reload  input  1  level; sampled at terminal count.
- count  output  WIDTH  current counter value, registered.
- busy  output  1  high while in RUN, registered.
- tc  output  1  terminal-count pulse, one cycle, registered.
- done  output  1  high while in DONE, registered.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on rst. rst has priority over every other input.
- Reset values: count=0, busy=0, tc=0, done=0, state=IDLE, internal reload_reg=0.
- States: IDLE, RUN, DONE. busy=1 exactly in RUN; done=1 exactly in DONE.
- tc defaults to 0 every cycle unless set as described below.
- Input priority within a cycle: rst > stop > start > pause.
- IDLE, start=1 and load_val!=0:
  - Next cycle: count=load_val, reload_reg=load_val, state=RUN, busy=1.
  - Latency from start to first decremented value is 2 cycles.
- IDLE, start=1 and load_val==0: ignored. State, count and flags are unchanged.
- IDLE, no start: count holds its last value.
- RUN, pause=1: count holds; no tc; pause has no effect outside RUN.
- RUN, pause=0 and count>1: count <= count-1.
- RUN, pause=0 and count==1 (terminal event), tc<=1 and then:
  - auto_reload=1: count<=reload_reg and state stays RUN. The period is exactly N cycles; count never shows 0.
  - auto_reload=0: count<=0, state<=DONE, busy<=0, done<=1.
- RUN, start=1: ignored. No restart and reload_reg is unchanged.
- RUN, stop=1: state<=IDLE, busy<=0, count holds its current value, no tc.
  - stop on the terminal cycle wins: no tc and no DONE.
- DONE:
  - done stays high and count stays 0 until start or stop.
  - start with load_val!=0: same as IDLE start; done<=0 on the same edge that loads count.
  - stop: IDLE, done<=0.
  - start with load_val==0: ignored, stays DONE.
- Arithmetic: unsigned WIDTH-bit. The decrement never wraps, because count==0 is never decremented.
  - Maximum load is 2^WIDTH-1 (15 at default).
- Reset mid-operation: the next cycle shows all reset values regardless of state. Any pending tc is suppressed.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst for 2 cycles mid-RUN with count=7 -> next cycle count=0, busy=0, done=0, tc=0, IDLE.
- One-shot: load_val=5, start pulse, auto_reload=0 -> count 5,4,3,2,1,0.
  - tc=1 on the cycle count becomes 0; done=1 from then on; busy high for 5 cycles.
- Auto-reload: load_val=3, auto_reload=1 -> count 3,2,1,3,2,1,...
  - tc pulses every 3 cycles on each reload cycle; done never asserts.
  - Drop auto_reload and confirm the next terminal event ends in DONE with count=0.
- Pause: load_val=4, assert pause for 3 cycles when count=2 -> count holds at 2 for 3 cycles, then 1, then 0 with tc, total busy of 7 cycles.
  - Pause held while count==1 gives no tc until pause is released.
- Stop and ignored start:
  - Start during RUN with load_val=9 -> no effect.
  - stop at count=3 -> IDLE, count stays 3, no tc.
  - stop and start in the same cycle -> stop wins.
- Boundaries:
  - start with load_val=0 -> no state change.
  - load_val=15 -> 15 counts to 0.
  - load_val=1 -> tc on the first decrement.
  - From DONE, start with load_val=2 -> done drops on the same edge that count=2 appears.
